// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Result layout: remainder in the upper half, quotient in the lower half.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 34;
  localparam int REM_LSB     = 32;
  localparam int QUO_LSB     = 0;
  localparam int CNT_W       = $clog2(DIV_ITERS);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational, no latency.
// No handshake: the caller decides when the step result is registered.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             trial_neg;

  always_comb begin
    rem_sh    = {rem_i, quo_i[WIDTH-1]};
    trial_neg = rem_sh < {1'b0, div_i};
    // When the trial subtraction succeeds the difference is below the divisor,
    // so the low WIDTH bits of the modular difference are exact.
    trial     = rem_sh[WIDTH-1:0] - div_i;
    if (!trial_neg) begin
      rem_o = trial;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider; result strobe 34 cycles after accept.
// Backpressure: s_axis_tready high only in IDLE; requests while busy are dropped.
module div_radix2
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter int WIDTH  = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               s_axis_tready,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept;

  // Unsigned instances tie the sign flags low so abs/negate folds away.
  assign sgn_a = SIGNED && s_axis_dividend_tdata[WIDTH-1];
  assign sgn_b = SIGNED && s_axis_divisor_tdata[WIDTH-1];
  assign mag_a = sgn_a ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign mag_b = sgn_b ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

  assign quo_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
  assign rem_fix = neg_a_q ? -rem_q : rem_q;

  assign accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          quo_d   = mag_a;
          dvs_d   = mag_b;
          rem_d   = '0;
          neg_a_d = sgn_a;
          neg_b_d = sgn_b;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        dout_d[REM_LSB +: WIDTH] = rem_fix;
        dout_d[QUO_LSB +: WIDTH] = quo_fix;
        dout_vld_d               = 1'b1;
        state_d                  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign s_axis_tready      = (state_q == IDLE);
  assign m_axis_dout_tvalid = dout_vld_q;
  assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_div_radix2.sv
// Bench for div_radix2: one signed and one unsigned instance with a
// scoreboard of expected {remainder, quotient} and expected strobe cycle.
module tb_div_radix2;
  import div_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        u_a_vld, u_b_vld, s_a_vld, s_b_vld;
  logic [31:0] u_a, u_b, s_a, s_b;
  logic        u_rdy, s_rdy, u_vld, s_vld;
  logic [63:0] u_dout, s_dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] dat;
    int          due;
  } exp_t;

  exp_t qu[$];
  exp_t qs[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  div_radix2 #(.SIGNED(1'b0), .WIDTH(32)) u_dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (u_a_vld),
    .s_axis_dividend_tdata  (u_a),
    .s_axis_divisor_tvalid  (u_b_vld),
    .s_axis_divisor_tdata   (u_b),
    .s_axis_tready          (u_rdy),
    .m_axis_dout_tvalid     (u_vld),
    .m_axis_dout_tdata      (u_dout)
  );

  div_radix2 #(.SIGNED(1'b1), .WIDTH(32)) s_dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (s_a_vld),
    .s_axis_dividend_tdata  (s_a),
    .s_axis_divisor_tvalid  (s_b_vld),
    .s_axis_divisor_tdata   (s_b),
    .s_axis_tready          (s_rdy),
    .m_axis_dout_tvalid     (s_vld),
    .m_axis_dout_tdata      (s_dout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      r = a;
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Called just after a rising edge; the request is accepted on the next edge.
  task automatic start(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    exp_t e;
    e.dat = exp;
    e.due = cyc + DIV_LATENCY;
    if (sgn) begin
      s_a = a; s_b = b; s_a_vld = 1'b1; s_b_vld = 1'b1;
      if (push) qs.push_back(e);
    end else begin
      u_a = a; u_b = b; u_a_vld = 1'b1; u_b_vld = 1'b1;
      if (push) qu.push_back(e);
    end
    @(posedge aclk); #1;
    u_a_vld = 1'b0; u_b_vld = 1'b0; s_a_vld = 1'b0; s_b_vld = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((qu.size() != 0 || qs.size() != 0) && n < budget) begin
      @(posedge aclk);
      n++;
    end
    #1;
    check("drain_pending", 64'(qu.size() + qs.size()), 64'd0);
  endtask

  always @(negedge aclk) begin
    exp_t e;
    if (u_vld === 1'b1) begin
      if (qu.size() == 0) check("u_spurious_vld", {63'd0, u_vld}, 64'd0);
      else begin
        e = qu.pop_front();
        check("u_dout", u_dout, e.dat);
        check("u_latency", 64'(cyc), 64'(e.due));
      end
    end
    if (s_vld === 1'b1) begin
      if (qs.size() == 0) check("s_spurious_vld", {63'd0, s_vld}, 64'd0);
      else begin
        e = qs.pop_front();
        check("s_dout", s_dout, e.dat);
        check("s_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    aresetn = 1'b0;
    u_a_vld = 1'b0; u_b_vld = 1'b0; s_a_vld = 1'b0; s_b_vld = 1'b0;
    u_a = '0; u_b = '0; s_a = '0; s_b = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    check("rst_u_rdy", {63'd0, u_rdy}, 64'd1);
    check("rst_s_rdy", {63'd0, s_rdy}, 64'd1);
    check("rst_u_vld", {63'd0, u_vld}, 64'd0);
    check("rst_s_vld", {63'd0, s_vld}, 64'd0);
    check("rst_u_dout", u_dout, 64'd0);
    check("rst_s_dout", s_dout, 64'd0);
    @(posedge aclk); #1;

    // Directed arithmetic cases
    start(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 1'b1);
    check("u_rdy_busy", {63'd0, u_rdy}, 64'd0);
    drain(60);
    start(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    drain(60);
    start(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1);
    drain(60);
    start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);
    drain(60);
    start(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0000_0000, 32'hFFFF_FFFF}, 1'b1);
    drain(60);
    start(1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1);
    drain(60);
    start(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h0000_0001}, 1'b1);
    drain(60);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      start(i[0], ra, rb, model(i[0], ra, rb), 1'b1);
      drain(60);
    end

    // Lone dividend valid must not start a division
    u_a = 32'd55; u_a_vld = 1'b1;
    repeat (3) @(posedge aclk);
    #1 u_a_vld = 1'b0;
    check("lone_u_rdy", {63'd0, u_rdy}, 64'd1);
    repeat (40) @(posedge aclk);
    #1 check("lone_u_vld", {63'd0, u_vld}, 64'd0);

    // Second request during CALC is dropped
    start(1'b1, 32'd1000, 32'hFFFF_FFFD, {32'h0000_0001, 32'hFFFF_FEB3}, 1'b1);
    repeat (5) @(posedge aclk);
    #1 s_a = 32'd50; s_b = 32'd5; s_a_vld = 1'b1; s_b_vld = 1'b1;
    @(posedge aclk);
    #1 s_a_vld = 1'b0; s_b_vld = 1'b0;
    drain(60);
    repeat (40) @(posedge aclk);
    #1 check("busy_drop_s_rdy", {63'd0, s_rdy}, 64'd1);

    // Back-to-back: second accept on the edge the first result is sampled
    start(1'b0, 32'd1000, 32'd33, {32'h0000_000A, 32'h0000_001E}, 1'b1);
    repeat (33) @(posedge aclk);
    #1 check("b2b_u_rdy", {63'd0, u_rdy}, 64'd1);
    start(1'b0, 32'd81, 32'd9, {32'h0000_0000, 32'h0000_0009}, 1'b1);
    drain(80);

    // Reset in the middle of a division
    start(1'b0, 32'hDEAD_BEEF, 32'd3, 64'd0, 1'b0);
    repeat (9) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1 check("midrst_u_vld", {63'd0, u_vld}, 64'd0);
    check("midrst_u_dout", u_dout, 64'd0);
    check("midrst_s_dout", s_dout, 64'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (40) @(posedge aclk);
    #1 check("postrst_u_dout", u_dout, 64'd0);
    check("postrst_u_rdy", {63'd0, u_rdy}, 64'd1);

    // Fresh requests after reset release
    start(1'b0, 32'd1000, 32'd7, {32'h0000_0006, 32'h0000_008E}, 1'b1);
    drain(60);
    start(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);
    drain(60);

    repeat (5) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
